watch_mode_ctrl: RTL and testbench
==================================

WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

Interface
REQ-001 Parameter NUM_MODES, default 7: number of mode blocks arbitrated (2..16).
REQ-002 Parameter DIGITS, default 6: display digits per mode.
REQ-003 Parameter SEG_W, default 8: bits per digit, active-low segments.
REQ-004 Parameter DEB_CYCLES, default 4: consecutive stable samples to accept a button level (1..255).
REQ-005 Parameter BLANK_CYCLES, default 2: display blank cycles after a mode change (0..255).
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 btn_n  in  6  raw active-low buttons, bit order {esc,enter,right,left,down,up} (bit5..bit0), asynchronous to clk.
REQ-009 mode_disp  in  NUM_MODES*DIGITS*SEG_W  per-mode digit buses, mode m at bits [m*DIGITS*SEG_W +: DIGITS*SEG_W].
REQ-010 mode_norm  in  NUM_MODES  1 = mode m idle (not editing), mode switching permitted.
REQ-011 mode_alarm  in  NUM_MODES  level alarm request from mode m.
REQ-012 btn_o  out  NUM_MODES*6  one-cycle button pulses, mode m at [m*6 +: 6], same bit order as btn_n.
REQ-013 mode_sel  out  ceil(log2(NUM_MODES))  index of active mode.
REQ-014 mode_led  out  NUM_MODES  one-hot of mode_sel.
REQ-015 disp_o  out  DIGITS*SEG_W  registered display bus.
REQ-016 alarm_o  out  1  latched alarm indicator.

Function
REQ-017 Each btn_n bit SHALL pass a 2-FF synchronizer, then an inverter to active-high.
REQ-018 Per button, a debounce counter SHALL update the accepted level only after DEB_CYCLES consecutive synchronized samples differ from it; any matching sample clears the counter.
REQ-019 A rising edge of an accepted level SHALL produce exactly one internal pulse cycle; holding a button SHALL produce no further pulses; raw-to-pulse latency 2+DEB_CYCLES+1 cycles.
REQ-020 Pulse handling priority per cycle: (1) alarm ack, (2) mode switch, (3) forward.
REQ-021 Alarm ack: if alarm_o=1, any pulse(s) SHALL clear alarm_o next cycle and SHALL be consumed (nothing forwarded, no mode change).
REQ-022 Mode switch: if alarm_o=0, mode_norm[mode_sel]=1 and exactly one of left/right pulses, mode_sel SHALL decrement (left) or increment (right) next cycle, wrapping NUM_MODES-1<->0; that pulse and all other same-cycle pulses SHALL be consumed.
REQ-023 Left and right pulsed in the same cycle with mode_norm[mode_sel]=1: no mode change, all pulses consumed.
REQ-024 Forward: otherwise, pulses SHALL appear on btn_o for mode_sel only, one cycle after the internal pulse; all other btn_o slices SHALL be 0.
REQ-025 FSM states RUN, BLANK: mode change enters BLANK for BLANK_CYCLES cycles (skipped if 0), then RUN; in BLANK all pulses are consumed and disp_o is all ones.
REQ-026 A left/right pulse in BLANK SHALL NOT change mode.
REQ-027 In RUN, disp_o SHALL register mode_disp slice of mode_sel (1-cycle latency).
REQ-028 alarm_o SHALL set on the cycle after any mode_alarm bit rises 0->1 (per-bit edge detect), regardless of active mode; a rise coinciding with an ack SHALL win (alarm_o stays 1).
REQ-029 mode_led SHALL equal 1<<mode_sel at all times.

Reset
REQ-030 rst_n=0 SHALL immediately force: mode_sel=0, mode_led=1, btn_o=0, disp_o all ones, alarm_o=0, FSM=RUN, debounce counters 0, accepted levels 0, synchronizers 0, alarm edge history = 0.
REQ-031 Reset asserted mid-debounce or mid-BLANK SHALL abandon the operation; no pulse generated from a press begun before deassertion until it is re-qualified from the synchronizers.
REQ-032 A button held through reset deassertion SHALL produce one pulse after qualification.

Verification
REQ-033 Defaults, mode 0 norm=1: press right 10 cycles -> mode_sel 0->1, mode_led=0000010, disp_o=1111..1 for 2 cycles then mode 1 digits; no btn_o pulse.
REQ-034 mode_sel=0, left press -> mode_sel=6; at mode 6 right press -> mode_sel=0.
REQ-035 mode_norm[2]=0, mode_sel=2, press right -> btn_o[2*6+3] high exactly one cycle, mode_sel stays 2, other slices 0.
REQ-036 Bounce: btn_n up toggling every 2 cycles for 20 cycles then stable low -> exactly one up pulse on active slice.
REQ-037 mode_alarm[4] rises while mode_sel=1 -> alarm_o=1; enter press -> alarm_o=0, no btn_o pulse; mode_alarm[4] held high -> alarm_o stays 0.
REQ-038 rst_n pulsed low during BLANK after switch to mode 3 -> mode_sel=0, disp_o all ones, alarm_o=0 immediately.

Source files
------------

// File: rtl/watch_mode_ctrl_if.sv
// Bundles the button, per-mode display/status and arbitrated output signals of watch_mode_ctrl.
// master drives the mode-side inputs; slave is the controller.
interface watch_mode_ctrl_if #(
  parameter int unsigned NUM_MODES = 7,
  parameter int unsigned DIGITS    = 6,
  parameter int unsigned SEG_W     = 8
);
  localparam int unsigned SelW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

  logic [5:0]                        btn_n;
  logic [NUM_MODES*DIGITS*SEG_W-1:0] mode_disp;
  logic [NUM_MODES-1:0]              mode_norm;
  logic [NUM_MODES-1:0]              mode_alarm;
  logic [NUM_MODES*6-1:0]            btn_o;
  logic [SelW-1:0]                   mode_sel;
  logic [NUM_MODES-1:0]              mode_led;
  logic [DIGITS*SEG_W-1:0]           disp_o;
  logic                              alarm_o;

  modport master (
    output btn_n, mode_disp, mode_norm, mode_alarm,
    input  btn_o, mode_sel, mode_led, disp_o, alarm_o
  );

  modport slave (
    input  btn_n, mode_disp, mode_norm, mode_alarm,
    output btn_o, mode_sel, mode_led, disp_o, alarm_o
  );
endinterface

// File: rtl/watch_mode_ctrl.sv
// Watch mode arbiter: debounces six buttons, switches between mode blocks with left/right,
// forwards other presses to the active mode, muxes its display and latches alarm requests.
module watch_mode_ctrl #(
  parameter int unsigned NUM_MODES    = 7,
  parameter int unsigned DIGITS       = 6,
  parameter int unsigned SEG_W        = 8,
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  watch_mode_ctrl_if.slave bus
);
  localparam int unsigned SelW     = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int unsigned DispW    = DIGITS * SEG_W;
  localparam int unsigned NB       = 6;
  localparam int unsigned BtnLeft  = 2;
  localparam int unsigned BtnRight = 3;

  typedef enum logic [0:0] {StRun, StBlank} state_e;

  logic [NB-1:0]          sync1_q, sync2_q, acc_q, acc_d, acc_prev_q, pulse;
  logic [7:0]             deb_cnt_q [NB];
  logic [7:0]             deb_cnt_d [NB];
  logic [NUM_MODES-1:0]   alarm_prev_q;
  logic                   alarm_q, alarm_d, alarm_rise, cur_norm;
  state_e                 state_q, state_d;
  logic [7:0]             blank_cnt_q, blank_cnt_d;
  logic [SelW-1:0]        sel_q, sel_d;
  logic [NUM_MODES*NB-1:0] btn_o_q, btn_o_d;
  logic [DispW-1:0]       disp_q, disp_d;
  logic [NUM_MODES-1:0]   led;

  // Any sample matching the accepted level restarts the stability count.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < NB; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != acc_q[i]) begin
        if (deb_cnt_q[i] == 8'(DEB_CYCLES - 1)) acc_d[i] = sync2_q[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
      end
    end
  end

  assign pulse      = acc_q & ~acc_prev_q;
  assign alarm_rise = |(bus.mode_alarm & ~alarm_prev_q);

  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    sel_d       = sel_q;
    alarm_d     = alarm_q;
    btn_o_d     = '0;
    cur_norm    = 1'b0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (SelW'(m) == sel_q) cur_norm = bus.mode_norm[m];
    end

    if (alarm_q && (|pulse)) alarm_d = 1'b0;

    if (state_q == StBlank) begin
      if (blank_cnt_q == 8'd0) state_d = StRun;
      else blank_cnt_d = blank_cnt_q - 8'd1;
    end else if (!alarm_q) begin
      if (cur_norm && (pulse[BtnLeft] || pulse[BtnRight])) begin
        if (pulse[BtnLeft] ^ pulse[BtnRight]) begin
          if (pulse[BtnRight]) begin
            sel_d = (sel_q == SelW'(NUM_MODES - 1)) ? '0 : sel_q + SelW'(1);
          end else begin
            sel_d = (sel_q == '0) ? SelW'(NUM_MODES - 1) : sel_q - SelW'(1);
          end
          if (BLANK_CYCLES != 0) begin
            state_d     = StBlank;
            blank_cnt_d = 8'(BLANK_CYCLES - 1);
          end
        end
      end else begin
        for (int m = 0; m < NUM_MODES; m++) begin
          if (SelW'(m) == sel_q) btn_o_d[m*NB +: NB] = pulse;
        end
      end
    end

    // A new alarm request outranks a same-cycle acknowledge.
    if (alarm_rise) alarm_d = 1'b1;

    disp_d = '1;
    if (state_d == StRun) begin
      for (int m = 0; m < NUM_MODES; m++) begin
        if (SelW'(m) == sel_d) disp_d = bus.mode_disp[m*DispW +: DispW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      acc_q        <= '0;
      acc_prev_q   <= '0;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= '0;
      alarm_prev_q <= '0;
      alarm_q      <= 1'b0;
      state_q      <= StRun;
      blank_cnt_q  <= '0;
      sel_q        <= '0;
      btn_o_q      <= '0;
      disp_q       <= '1;
    end else begin
      // Inverting ahead of the first flop keeps a reset synchronizer at "released".
      sync1_q      <= ~bus.btn_n;
      sync2_q      <= sync1_q;
      acc_q        <= acc_d;
      acc_prev_q   <= acc_q;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      alarm_prev_q <= bus.mode_alarm;
      alarm_q      <= alarm_d;
      state_q      <= state_d;
      blank_cnt_q  <= blank_cnt_d;
      sel_q        <= sel_d;
      btn_o_q      <= btn_o_d;
      disp_q       <= disp_d;
    end
  end

  always_comb begin
    led = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (SelW'(m) == sel_q) led[m] = 1'b1;
    end
  end

  assign bus.btn_o    = btn_o_q;
  assign bus.mode_sel = sel_q;
  assign bus.mode_led = led;
  assign bus.disp_o   = disp_q;
  assign bus.alarm_o  = alarm_q;
endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench for watch_mode_ctrl; forwarded button pulses are checked against a scoreboard.
module tb_watch_mode_ctrl;
  localparam int unsigned NM = 7;
  localparam int unsigned DG = 6;
  localparam int unsigned SW = 8;
  localparam int unsigned DW = DG * SW;
  localparam int BUp = 0, BLeft = 2, BRight = 3, BEnter = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [63:0] sb_q[$];

  watch_mode_ctrl_if #(.NUM_MODES(NM), .DIGITS(DG), .SEG_W(SW)) bus ();

  watch_mode_ctrl #(
    .NUM_MODES(NM), .DIGITS(DG), .SEG_W(SW), .DEB_CYCLES(4), .BLANK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] disp_of(int m);
    logic [DW-1:0] r;
    logic [3:0]    mm;
    mm = 4'(m);
    for (int d = 0; d < DG; d++) r[d*SW +: SW] = {mm, 4'(d)};
    return r;
  endfunction

  function automatic logic [63:0] btn_bit(int m, int b);
    logic [63:0] one;
    one = 64'd1;
    return one << (m * 6 + b);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int b, input int hold);
    bus.btn_n[b] = 1'b0;
    tick(hold);
    bus.btn_n[b] = 1'b1;
    tick(15);
  endtask

  task automatic wait_sel(input int target, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mode_sel == 3'(target)) break;
    end
    check(tag, 64'(bus.mode_sel), 64'(target));
  endtask

  // Every nonzero btn_o cycle must match the next expected pulse.
  always @(negedge clk) begin
    if (rst_n && bus.btn_o != '0) begin
      if (sb_q.size() == 0) check("btn_o_unexpected", 64'(bus.btn_o), 64'd0);
      else check("btn_o", 64'(bus.btn_o), sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.btn_n      = 6'h3f;
    bus.mode_norm  = '1;
    bus.mode_alarm = '0;
    for (int m = 0; m < NM; m++) bus.mode_disp[m*DW +: DW] = disp_of(m);

    tick(3);
    @(negedge clk);
    check("rst_sel", 64'(bus.mode_sel), 64'd0);
    check("rst_led", 64'(bus.mode_led), 64'h01);
    check("rst_btn_o", 64'(bus.btn_o), 64'd0);
    check("rst_disp", 64'(bus.disp_o), 64'hffff_ffff_ffff);
    check("rst_alarm", 64'(bus.alarm_o), 64'd0);
    rst_n = 1'b1;
    tick(3);
    @(negedge clk);
    check("disp_mode0", 64'(bus.disp_o), 64'(disp_of(0)));

    // Right from mode 0: blank for two cycles, then mode 1 digits.
    bus.btn_n[BRight] = 1'b0;
    wait_sel(1, "sel_right_0to1");
    check("led_mode1", 64'(bus.mode_led), 64'h02);
    check("disp_blank0", 64'(bus.disp_o), 64'hffff_ffff_ffff);
    @(negedge clk);
    check("disp_blank1", 64'(bus.disp_o), 64'hffff_ffff_ffff);
    @(negedge clk);
    check("disp_mode1", 64'(bus.disp_o), 64'(disp_of(1)));
    tick(3);
    bus.btn_n[BRight] = 1'b1;
    tick(15);

    // Wrap both ways.
    press(BLeft, 10);
    press(BLeft, 10);
    check("sel_wrap_left", 64'(bus.mode_sel), 64'd6);
    press(BRight, 10);
    check("sel_wrap_right", 64'(bus.mode_sel), 64'd0);

    // Mode 2 editing: right is forwarded instead of switching.
    press(BRight, 10);
    press(BRight, 10);
    bus.mode_norm[2] = 1'b0;
    sb_q.push_back(btn_bit(2, BRight));
    press(BRight, 10);
    check("sel_stay2", 64'(bus.mode_sel), 64'd2);

    // Bouncing up button gives a single pulse.
    sb_q.push_back(btn_bit(2, BUp));
    for (int k = 0; k < 5; k++) begin
      bus.btn_n[BUp] = 1'b0;
      tick(2);
      bus.btn_n[BUp] = 1'b1;
      tick(2);
    end
    press(BUp, 10);

    // Idle mode still forwards non-navigation buttons.
    bus.mode_norm[2] = 1'b1;
    sb_q.push_back(btn_bit(2, BUp));
    press(BUp, 10);
    press(BLeft, 10);
    check("sel_back1", 64'(bus.mode_sel), 64'd1);

    // Alarm from an inactive mode, acknowledged by enter.
    bus.mode_alarm[4] = 1'b1;
    tick(1);
    @(negedge clk);
    check("alarm_set", 64'(bus.alarm_o), 64'd1);
    press(BEnter, 10);
    check("alarm_ack", 64'(bus.alarm_o), 64'd0);
    check("sel_after_ack", 64'(bus.mode_sel), 64'd1);
    tick(5);
    check("alarm_held_level", 64'(bus.alarm_o), 64'd0);
    sb_q.push_back(btn_bit(1, BEnter));
    press(BEnter, 10);
    bus.mode_alarm[4] = 1'b0;

    // Simultaneous left+right in an idle mode does nothing.
    bus.btn_n[BLeft]  = 1'b0;
    bus.btn_n[BRight] = 1'b0;
    tick(10);
    bus.btn_n[BLeft]  = 1'b1;
    bus.btn_n[BRight] = 1'b1;
    tick(15);
    check("sel_both_lr", 64'(bus.mode_sel), 64'd1);

    // Reset during blank, right held through deassertion.
    press(BRight, 10);
    bus.btn_n[BRight] = 1'b0;
    wait_sel(3, "sel_to3");
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 64'(bus.mode_sel), 64'd0);
    check("mid_rst_led", 64'(bus.mode_led), 64'h01);
    check("mid_rst_disp", 64'(bus.disp_o), 64'hffff_ffff_ffff);
    check("mid_rst_alarm", 64'(bus.alarm_o), 64'd0);
    tick(3);
    rst_n = 1'b1;
    tick(12);
    bus.btn_n[BRight] = 1'b1;
    tick(15);
    check("sel_held_thru_rst", 64'(bus.mode_sel), 64'd1);

    tick(5);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
